// File: rtl/hazard_tracker.sv
// hazard_tracker: stall and forwarding-select generation for a 5-stage pipeline.
// Decode supplies each instruction's source registers, their use times (Tuse),
// its destination register and its result latency (Tnew). A shadow E/M/W
// pipeline of those fields is kept here. The shadow pipeline is compared
// against the decode-stage sources to decide whether to hold and which stage
// to forward from.
module hazard_tracker #(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_d,
  input  logic [ADDR_W-1:0] rt_d,
  input  logic [1:0]        rs_use_d,
  input  logic [1:0]        rt_use_d,
  input  logic [ADDR_W-1:0] a3_d,
  input  logic [TNEW_W-1:0] tnew_d,
  output logic              stall,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m
);

  // Tnew and Tuse can differ in width; compare them zero-extended to a common width.
  localparam int CMP_W = (TNEW_W > 2) ? TNEW_W : 2;

  localparam logic [1:0] USE_NONE = 2'b11;

  // Forwarding source codes shared by the D- and E-stage selects.
  localparam logic [1:0] SRC_RF = 2'b00;
  localparam logic [1:0] SRC_E  = 2'b01;
  localparam logic [1:0] SRC_M  = 2'b10;
  localparam logic [1:0] SRC_W  = 2'b11;

  // Shadow pipeline. W never needs a Tnew because a result there is always ready.
  logic [ADDR_W-1:0] a3_e;
  logic [ADDR_W-1:0] rs_e;
  logic [ADDR_W-1:0] rt_e;
  logic [TNEW_W-1:0] tnew_e;
  logic [ADDR_W-1:0] a3_m;
  logic [ADDR_W-1:0] rt_m;
  logic [TNEW_W-1:0] tnew_m;
  logic [ADDR_W-1:0] a3_w;

  logic stall_rs;
  logic stall_rt;

  // One cycle of latency elapses per stage, but the count stops at zero.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    logic [TNEW_W-1:0] res;
    if (x == '0) res = '0;
    else         res = x - TNEW_W'(1);
    return res;
  endfunction

  // A writer is too late when its result appears after the reader needs it.
  function automatic logic too_late(input logic [TNEW_W-1:0] tnew,
                                    input logic [1:0]        use_t);
    logic [CMP_W-1:0] t_x;
    logic [CMP_W-1:0] u_x;
    t_x = CMP_W'(tnew);
    u_x = CMP_W'(use_t);
    return t_x > u_x;
  endfunction

  // $0 is hard-wired, so it never matches a pending writer.
  function automatic logic hit(input logic [ADDR_W-1:0] dst,
                               input logic [ADDR_W-1:0] src);
    return (src != '0) && (dst == src);
  endfunction

  // Stall when the nearest pending writer of src cannot deliver in time.
  function automatic logic stall_for(input logic [ADDR_W-1:0] src,
                                     input logic [1:0]        use_t,
                                     input logic [ADDR_W-1:0] ae,
                                     input logic [TNEW_W-1:0] te,
                                     input logic [ADDR_W-1:0] am,
                                     input logic [TNEW_W-1:0] tm);
    logic res;
    res = 1'b0;
    if (use_t != USE_NONE) begin
      if (hit(ae, src))      res = too_late(te, use_t);
      else if (hit(am, src)) res = too_late(tm, use_t);
    end
    return res;
  endfunction

  // D-stage select: the nearest writer only, and only once its value exists.
  // A nearer writer that is not ready shadows any older one, so RF is chosen
  // and a later-stage select picks the value up once it is produced.
  function automatic logic [1:0] src_d(input logic [ADDR_W-1:0] src,
                                       input logic [ADDR_W-1:0] ae,
                                       input logic [TNEW_W-1:0] te,
                                       input logic [ADDR_W-1:0] am,
                                       input logic [TNEW_W-1:0] tm,
                                       input logic [ADDR_W-1:0] aw);
    logic [1:0] sel;
    sel = SRC_RF;
    if (hit(ae, src)) begin
      if (te == '0) sel = SRC_E;
    end else if (hit(am, src)) begin
      if (tm == '0) sel = SRC_M;
    end else if (hit(aw, src)) begin
      sel = SRC_W;
    end
    return sel;
  endfunction

  // E-stage select: M when ready, W only when M does not also write the register.
  function automatic logic [1:0] src_e(input logic [ADDR_W-1:0] src,
                                       input logic [ADDR_W-1:0] am,
                                       input logic [TNEW_W-1:0] tm,
                                       input logic [ADDR_W-1:0] aw);
    logic [1:0] sel;
    sel = SRC_RF;
    if (hit(am, src)) begin
      if (tm == '0) sel = SRC_M;
    end else if (hit(aw, src)) begin
      sel = SRC_W;
    end
    return sel;
  endfunction

  // Hazard detection and forwarding selects, all purely combinational.
  always_comb begin
    stall_rs = stall_for(rs_d, rs_use_d, a3_e, tnew_e, a3_m, tnew_m);
    stall_rt = stall_for(rt_d, rt_use_d, a3_e, tnew_e, a3_m, tnew_m);
    stall    = stall_rs | stall_rt;
    fwd_rs_d = src_d(rs_d, a3_e, tnew_e, a3_m, tnew_m, a3_w);
    fwd_rt_d = src_d(rt_d, a3_e, tnew_e, a3_m, tnew_m, a3_w);
    fwd_rs_e = src_e(rs_e, a3_m, tnew_m, a3_w);
    fwd_rt_e = src_e(rt_e, a3_m, tnew_m, a3_w);
    fwd_rt_m = hit(a3_w, rt_m);
  end

  // D -> E boundary: take the decoded fields, or a bubble while D is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_e   <= '0;
      tnew_e <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
    end else if (stall) begin
      a3_e   <= '0;
      tnew_e <= '0;
      rs_e   <= '0;
      rt_e   <= '0;
    end else begin
      a3_e   <= a3_d;
      tnew_e <= tnew_d;
      rs_e   <= rs_d;
      rt_e   <= rt_d;
    end
  end

  // E -> M -> W boundaries: these always advance, stall or not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a3_m   <= '0;
      tnew_m <= '0;
      rt_m   <= '0;
      a3_w   <= '0;
    end else begin
      a3_m   <= a3_e;
      tnew_m <= sat_dec(tnew_e);
      rt_m   <= rt_e;
      a3_w   <= a3_m;
    end
  end

endmodule
